// File: rtl/edge_freq_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : edge_freq_counter
// Description : Gated frequency meter. Counts rising edges of an asynchronous
//               input over windows bounded by a one-cycle gate_tick pulse and
//               latches each completed window's count as the result.
// Revision    : 1.0  initial release
// ============================================================================
module edge_freq_counter #(
  parameter int CNT_W    = 24,
  parameter int SYNC_LEN = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             gate_tick,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             count_ovf,
  output logic             armed
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2
  } state_t;

  state_t               r_state;
  logic [SYNC_LEN-1:0]  r_sync;
  logic                 r_dly;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;
  logic [CNT_W-1:0]     r_freq;
  logic                 r_valid;
  logic                 r_freq_ovf;
  logic                 r_armed;

  logic                 w_edge;
  logic                 w_cnt_max;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_ovf_nxt;

  // Metastability synchronizer on sig_in followed by one delay flop for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_LEN-2:0], sig_in};
      r_dly  <= r_sync[SYNC_LEN-1];
    end
  end

  // Rising edge of the synchronized input, and the saturating next count/ovf values
  always_comb begin
    w_edge    = r_sync[SYNC_LEN-1] & ~r_dly;
    w_cnt_max = (r_cnt == c_CNT_MAX);
    w_cnt_nxt = r_cnt;
    if (w_edge && !w_cnt_max) begin
      w_cnt_nxt = r_cnt + c_CNT_ONE;
    end
    w_ovf_nxt = r_ovf | (w_edge & w_cnt_max);
  end

  // Window state machine: arm on first tick, then close/report a window on every tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_freq     <= '0;
      r_valid    <= 1'b0;
      r_freq_ovf <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt   <= '0;
          r_ovf   <= 1'b0;
          r_armed <= 1'b0;
          if (en) begin
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          // The window in progress when enabled is partial, so it is never reported
          r_cnt <= '0;
          r_ovf <= 1'b0;
          if (!en) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
          end else if (gate_tick) begin
            r_state <= S_COUNT;
            r_armed <= 1'b1;
          end
        end
        S_COUNT: begin
          if (!en) begin
            // Disable wins over a coincident tick; the open window is dropped
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end else if (gate_tick) begin
            // Close the window, including any edge landing on the tick cycle
            r_freq     <= w_cnt_nxt;
            r_freq_ovf <= w_ovf_nxt;
            r_valid    <= 1'b1;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
          end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_armed <= 1'b0;
          r_cnt   <= '0;
          r_ovf   <= 1'b0;
        end
      endcase
    end
  end

  assign freq_count  = r_freq;
  assign count_valid = r_valid;
  assign count_ovf   = r_freq_ovf;
  assign armed       = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_edge_freq_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_edge_freq_counter
// Description : Directed self-checking bench for edge_freq_counter. A second
//               instance with a 4-bit counter exercises saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_edge_freq_counter;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        gate_tick;
  logic        sig_in;

  logic [23:0] freq_count;
  logic        count_valid;
  logic        count_ovf;
  logic        armed;

  logic [3:0]  freq4;
  logic        valid4;
  logic        ovf4;
  logic        armed4;

  int          checks;
  int          errors;
  int          gph;
  int          nvmid;
  int          nvlast;

  edge_freq_counter #(.CNT_W(24), .SYNC_LEN(2)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .gate_tick   (gate_tick),
    .sig_in      (sig_in),
    .freq_count  (freq_count),
    .count_valid (count_valid),
    .count_ovf   (count_ovf),
    .armed       (armed)
  );

  edge_freq_counter #(.CNT_W(4), .SYNC_LEN(2)) u_dut4 (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .gate_tick   (gate_tick),
    .sig_in      (sig_in),
    .freq_count  (freq4),
    .count_valid (valid4),
    .count_ovf   (ovf4),
    .armed       (armed4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive ncyc clock cycles of a periodic sig_in (phase continues across calls
  // via gph); optional gate_tick on the last cycle; optional sub-cycle glitch
  // inside a low phase that never spans a clock edge. Records count_valid
  // pulses seen before and on the last cycle.
  task automatic window(input int ncyc, input int period, input int high,
                        input bit glitch, input bit do_gate);
    int ph;
    nvmid  = 0;
    nvlast = 0;
    for (int i = 0; i < ncyc; i++) begin
      ph        = gph % period;
      sig_in    = (ph < high);
      gate_tick = do_gate && (i == ncyc - 1);
      if (glitch && ph == high + 1) begin
        #2 sig_in = 1'b1;
        #3 sig_in = 1'b0;
      end
      @(posedge clk);
      #1;
      gph++;
      if (count_valid) begin
        if (i == ncyc - 1) nvlast = 1;
        else               nvmid++;
      end
    end
    gate_tick = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    gph       = 0;
    reset_n   = 1'b0;
    en        = 1'b0;
    gate_tick = 1'b0;
    sig_in    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_freq",  {8'b0, freq_count}, 32'd0);
    check("rst_valid", {31'b0, count_valid}, 32'd0);
    check("rst_ovf",   {31'b0, count_ovf}, 32'd0);
    check("rst_armed", {31'b0, armed}, 32'd0);
    reset_n = 1'b1;
    window(5, 10, 5, 1'b0, 1'b1);
    check("idle_armed", {31'b0, armed}, 32'd0);
    check("idle_valid", nvmid + nvlast, 32'd0);

    // Period 10, 1000-clk windows: first tick arms only, later ticks report 100
    en = 1'b1;
    window(500, 10, 5, 1'b0, 1'b0);
    check("arm_wait_armed", {31'b0, armed}, 32'd0);
    window(500, 10, 5, 1'b0, 1'b1);
    check("arm_tick_armed", {31'b0, armed}, 32'd1);
    check("arm_tick_novalid", nvmid + nvlast, 32'd0);
    window(1000, 10, 5, 1'b0, 1'b1);
    check("p10_w1_valid", nvlast, 32'd1);
    check("p10_w1_freq",  {8'b0, freq_count}, 32'd100);
    check("p10_w1_ovf",   {31'b0, count_ovf}, 32'd0);
    window(1000, 10, 5, 1'b0, 1'b1);
    check("p10_w2_single", nvmid, 32'd0);
    check("p10_w2_valid",  nvlast, 32'd1);
    check("p10_w2_freq",   {8'b0, freq_count}, 32'd100);
    check("p10_w2_armed",  {31'b0, armed}, 32'd1);

    // Asynchronous reset mid-window clears outputs without waiting for a clock
    window(300, 10, 5, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_freq",  {8'b0, freq_count}, 32'd0);
    check("arst_valid", {31'b0, count_valid}, 32'd0);
    check("arst_ovf",   {31'b0, count_ovf}, 32'd0);
    check("arst_armed", {31'b0, armed}, 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    gph++;
    check("arst_idle_armed", {31'b0, armed}, 32'd0);

    // Saturation on the 4-bit instance: 20 edges -> 15 + ovf, then 5 edges -> 5
    window(200, 10, 5, 1'b0, 1'b1);
    check("sat_arm_novalid", nvmid + nvlast, 32'd0);
    window(200, 10, 5, 1'b0, 1'b1);
    check("sat_w1_freq4",  {28'b0, freq4}, 32'd15);
    check("sat_w1_ovf4",   {31'b0, ovf4}, 32'd1);
    check("sat_w1_valid4", {31'b0, valid4}, 32'd1);
    check("sat_w1_freq",   {8'b0, freq_count}, 32'd20);
    check("sat_w1_ovf",    {31'b0, count_ovf}, 32'd0);
    window(50, 10, 5, 1'b0, 1'b1);
    check("sat_w2_freq4", {28'b0, freq4}, 32'd5);
    check("sat_w2_ovf4",  {31'b0, ovf4}, 32'd0);
    check("sat_w2_freq",  {8'b0, freq_count}, 32'd5);

    // Edge landing on the closing tick: 7 inner edges + 1 on the tick = 8,
    // and the following window starts from zero
    gph = 3;
    window(80, 10, 5, 1'b0, 1'b1);
    window(80, 10, 5, 1'b0, 1'b1);
    check("coinc_valid", nvlast, 32'd1);
    check("coinc_freq",  {8'b0, freq_count}, 32'd8);
    window(80, 10, 5, 1'b0, 1'b1);
    check("coinc_next_freq", {8'b0, freq_count}, 32'd8);

    // Drop en mid-window: nothing reported, result held, re-arm needed
    window(400, 10, 5, 1'b0, 1'b0);
    en = 1'b0;
    window(1, 10, 5, 1'b0, 1'b0);
    check("dis_armed", {31'b0, armed}, 32'd0);
    check("dis_valid", nvlast, 32'd0);
    check("dis_freq",  {8'b0, freq_count}, 32'd8);
    window(50, 10, 5, 1'b0, 1'b1);
    check("dis_tick_valid", nvmid + nvlast, 32'd0);
    check("dis_tick_freq",  {8'b0, freq_count}, 32'd8);
    en = 1'b1;
    window(100, 10, 5, 1'b0, 1'b1);
    check("rearm_novalid", nvmid + nvlast, 32'd0);
    check("rearm_armed",   {31'b0, armed}, 32'd1);
    window(1000, 10, 5, 1'b0, 1'b1);
    check("rearm_freq",  {8'b0, freq_count}, 32'd100);
    check("rearm_valid", nvlast, 32'd1);

    // en falling on the same cycle as gate_tick: window discarded
    window(500, 10, 5, 1'b0, 1'b0);
    en = 1'b0;
    window(1, 10, 5, 1'b0, 1'b1);
    check("en_vs_tick_valid", nvlast, 32'd0);
    check("en_vs_tick_freq",  {8'b0, freq_count}, 32'd100);
    check("en_vs_tick_armed", {31'b0, armed}, 32'd0);

    // 2-cycle pulses, period 8, with sub-cycle glitches -> 125 per 1000 clk
    en  = 1'b1;
    gph = 0;
    window(1000, 8, 2, 1'b1, 1'b1);
    window(1000, 8, 2, 1'b1, 1'b1);
    check("glitch_w1_freq",  {8'b0, freq_count}, 32'd125);
    check("glitch_w1_valid", nvlast, 32'd1);
    window(1000, 8, 2, 1'b1, 1'b1);
    check("glitch_w2_freq", {8'b0, freq_count}, 32'd125);
    check("glitch_w2_ovf",  {31'b0, count_ovf}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
